// File: rtl/mix_io_pkg.sv
// Shared constants for the MIX character I/O units: MIX code points,
// ASCII bytes used by the output path and the line-terminator selection.
package mix_io_pkg;

   // MIX character codes with special meaning on output
   localparam int BLANK   = 0;
   localparam int LF_CODE = 10;
   localparam int CR_CODE = 20;
   localparam int BEL_CODE = 21;
   localparam int NUM_CODES = 56;

   // ASCII bytes produced by the output path
   localparam logic [6:0] ASCII_CR    = 7'd13;
   localparam logic [6:0] ASCII_LF    = 7'd10;
   localparam logic [6:0] ASCII_BEL   = 7'd7;
   localparam logic [6:0] ASCII_SPACE = 7'd32;
   localparam logic [6:0] ASCII_BAD   = 7'd63;

   // Line terminator appended after the last word of a block
   typedef enum logic [1:0] {
      EOL_CRLF = 2'd0,
      EOL_LF   = 2'd1,
      EOL_NONE = 2'd2
   } eol_mode_t;

endpackage

// File: rtl/mix_to_ascii.sv
// Combinational MIX character code to 7-bit ASCII table. Codes outside the
// 56-entry character set come back as '?' with valid low.
module mix_to_ascii
   import mix_io_pkg::*;
#(
   parameter int CHAR_W = 6
) (
   input  logic [CHAR_W-1:0] code,
   output logic [6:0]        ascii,
   output logic              valid
);

   // Table lookup; letters and digits are contiguous runs, punctuation is listed
   always_comb begin
      int c;
      c     = int'(code);
      valid = (c < NUM_CODES);
      ascii = ASCII_BAD;
      if (c == BLANK)                ascii = ASCII_SPACE;
      else if (c >= 1 && c <= 9)     ascii = 7'(c + 64);   // A..I
      else if (c == LF_CODE)         ascii = ASCII_LF;
      else if (c >= 11 && c <= 19)   ascii = 7'(c + 63);   // J..R
      else if (c == CR_CODE)         ascii = ASCII_CR;
      else if (c == BEL_CODE)        ascii = ASCII_BEL;
      else if (c >= 22 && c <= 29)   ascii = 7'(c + 61);   // S..Z
      else if (c >= 30 && c <= 39)   ascii = 7'(c + 18);   // 0..9
      else begin
         case (c)
            40: ascii = 7'h2E;  // .
            41: ascii = 7'h2C;  // ,
            42: ascii = 7'h28;  // (
            43: ascii = 7'h29;  // )
            44: ascii = 7'h2B;  // +
            45: ascii = 7'h2D;  // -
            46: ascii = 7'h2A;  // *
            47: ascii = 7'h2F;  // /
            48: ascii = 7'h3D;  // =
            49: ascii = 7'h24;  // $
            50: ascii = 7'h3C;  // <
            51: ascii = 7'h3E;  // >
            52: ascii = 7'h40;  // @
            53: ascii = 7'h3B;  // ;
            54: ascii = 7'h3A;  // :
            55: ascii = 7'h27;  // '
            default: ascii = ASCII_BAD;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. ready is high while idle; a load while ready starts
// a frame. The line idles high and returns high immediately on reset.
module UartTX #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic             active_reg;
   logic [9:0]       shift_reg;
   logic [3:0]       bit_reg;
   logic [DIV_W-1:0] div_reg;

   // Frame shifter: start bit, 8 data bits LSB first, stop bit
   always_ff @(posedge clk) begin
      if (reset) begin
         active_reg <= 1'b0;
         shift_reg  <= '1;
         bit_reg    <= '0;
         div_reg    <= '0;
      end else if (!active_reg) begin
         if (load) begin
            active_reg <= 1'b1;
            shift_reg  <= {1'b1, data, 1'b0};
            bit_reg    <= '0;
            div_reg    <= '0;
         end
      end else if (div_reg == DIV_W'(CLKS_PER_BIT - 1)) begin
         div_reg   <= '0;
         shift_reg <= {1'b1, shift_reg[9:1]};
         if (bit_reg == 4'd9) active_reg <= 1'b0;
         else                 bit_reg    <= bit_reg + 4'd1;
      end else begin
         div_reg <= div_reg + DIV_W'(1);
      end
   end

   assign ready = !active_reg;
   assign tx    = active_reg ? shift_reg[0] : 1'b1;

endmodule

// File: rtl/mix_char_out.sv
// MIX character-output unit: fetches a block of words from CPU memory on an
// OUT command, translates each MIX character to ASCII and sends it over the
// UART, then appends the line terminator. One further OUT may be queued.
module mix_char_out
   import mix_io_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int WORDS        = 14,
   parameter int CHARS        = 5,
   parameter int CHAR_W       = 6,
   parameter int EOL_MODE     = 0,
   parameter int TRIM         = 0,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        addressin,
   output logic [ADDR_W-1:0]        addressout,
   output logic                     request,
   input  logic                     load,
   input  logic [CHARS*CHAR_W-1:0]  in,
   output logic                     stop,
   output logic                     busy,
   output logic                     bad_char,
   output logic                     tx
);

   localparam int        WORD_W = CHARS * CHAR_W;
   localparam int        CW     = (CHARS > 1) ? $clog2(CHARS) : 1;
   localparam int        WW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int        BLK_W  = $clog2(WORDS * CHARS + 1);
   localparam eol_mode_t EOL    = eol_mode_t'(EOL_MODE);

   logic              busy_reg, request_reg, stop_reg, bad_reg;
   logic              run_reg, eol_reg, eol_idx_reg;
   logic              pend_valid_reg;
   logic [ADDR_W-1:0] addr_reg, pend_addr_reg;
   logic [WORD_W-1:0] word_reg;
   logic [CW-1:0]     char_cnt_reg;
   logic [WW-1:0]     word_cnt_reg;
   logic [BLK_W-1:0]  blank_cnt_reg;

   logic              uart_ready, uart_load;
   logic [7:0]        uart_data;
   logic              char_adv, blank_inc, blank_dec, eol_adv;
   logic              last_char, last_word, block_end;
   logic [CHAR_W-1:0] slot [CHARS];
   logic [CHAR_W-1:0] cur_code;
   logic [6:0]        char_ascii;
   logic              char_valid;

   // Character slot 0 is the most significant character of the word
   for (genvar gi = 0; gi < CHARS; gi++) begin : g_slot
      assign slot[gi] = word_reg[(CHARS - gi) * CHAR_W - 1 -: CHAR_W];
   end

   assign cur_code = slot[char_cnt_reg];

   mix_to_ascii #(.CHAR_W(CHAR_W)) u_xlat (
      .code  (cur_code),
      .ascii (char_ascii),
      .valid (char_valid)
   );

   UartTX #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk   (clk),
      .reset (reset),
      .load  (uart_load),
      .data  (uart_data),
      .ready (uart_ready),
      .tx    (tx)
   );

   // Decide what, if anything, goes to the UART this cycle
   always_comb begin
      uart_load = 1'b0;
      uart_data = 8'h00;
      char_adv  = 1'b0;
      blank_inc = 1'b0;
      blank_dec = 1'b0;
      eol_adv   = 1'b0;
      if (busy_reg && run_reg) begin
         if (TRIM != 0 && cur_code == CHAR_W'(BLANK)) begin
            // blanks are only counted; they are emitted if a non-blank follows
            char_adv  = 1'b1;
            blank_inc = 1'b1;
         end else if (uart_ready) begin
            uart_load = 1'b1;
            if (TRIM != 0 && blank_cnt_reg != '0) begin
               uart_data = {1'b0, ASCII_SPACE};
               blank_dec = 1'b1;
            end else begin
               uart_data = {1'b0, char_ascii};
               char_adv  = 1'b1;
            end
         end
      end else if (busy_reg && eol_reg && uart_ready) begin
         uart_load = 1'b1;
         eol_adv   = 1'b1;
         uart_data = (EOL == EOL_CRLF && !eol_idx_reg) ? {1'b0, ASCII_CR}
                                                       : {1'b0, ASCII_LF};
      end
   end

   assign last_char = char_adv && (char_cnt_reg == CW'(CHARS - 1));
   assign last_word = (word_cnt_reg == WW'(WORDS - 1));
   assign block_end = (last_char && last_word && EOL == EOL_NONE) ||
                      (eol_adv && (EOL != EOL_CRLF || eol_idx_reg));

   // Block sequencing: start, word fetch, char/terminator progress, chaining
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg       <= 1'b0;
         request_reg    <= 1'b0;
         stop_reg       <= 1'b0;
         bad_reg        <= 1'b0;
         run_reg        <= 1'b0;
         eol_reg        <= 1'b0;
         eol_idx_reg    <= 1'b0;
         pend_valid_reg <= 1'b0;
         addr_reg       <= '0;
         pend_addr_reg  <= '0;
         word_reg       <= '0;
         char_cnt_reg   <= '0;
         word_cnt_reg   <= '0;
         blank_cnt_reg  <= '0;
      end else begin
         stop_reg <= 1'b0;
         if (!busy_reg) begin
            if (start) begin
               busy_reg       <= 1'b1;
               stop_reg       <= 1'b1;
               request_reg    <= 1'b1;
               addr_reg       <= addressin;
               bad_reg        <= 1'b0;
               run_reg        <= 1'b0;
               eol_reg        <= 1'b0;
               eol_idx_reg    <= 1'b0;
               pend_valid_reg <= 1'b0;
               char_cnt_reg   <= '0;
               word_cnt_reg   <= '0;
               blank_cnt_reg  <= '0;
            end
         end else begin
            if (request_reg && load) begin
               word_reg    <= in;
               request_reg <= 1'b0;
               run_reg     <= 1'b1;
            end
            if (blank_inc) blank_cnt_reg <= blank_cnt_reg + BLK_W'(1);
            if (blank_dec) blank_cnt_reg <= blank_cnt_reg - BLK_W'(1);
            if (char_adv && !char_valid) bad_reg <= 1'b1;
            if (char_adv) begin
               if (last_char) begin
                  char_cnt_reg <= '0;
                  run_reg      <= 1'b0;
                  if (last_word) begin
                     if (EOL != EOL_NONE) eol_reg <= 1'b1;
                  end else begin
                     word_cnt_reg <= word_cnt_reg + WW'(1);
                     request_reg  <= 1'b1;
                     addr_reg     <= addr_reg + ADDR_W'(1);
                  end
               end else begin
                  char_cnt_reg <= char_cnt_reg + CW'(1);
               end
            end
            if (eol_adv) eol_idx_reg <= 1'b1;
            if (block_end) begin
               run_reg       <= 1'b0;
               eol_reg       <= 1'b0;
               eol_idx_reg   <= 1'b0;
               char_cnt_reg  <= '0;
               word_cnt_reg  <= '0;
               blank_cnt_reg <= '0;
               if (pend_valid_reg) begin
                  addr_reg       <= pend_addr_reg;
                  pend_valid_reg <= 1'b0;
                  request_reg    <= 1'b1;
                  stop_reg       <= 1'b1;
               end else if (start) begin
                  // a start landing on the last cycle becomes the next block
                  addr_reg    <= addressin;
                  request_reg <= 1'b1;
                  stop_reg    <= 1'b1;
               end else begin
                  busy_reg <= 1'b0;
               end
            end else if (start && !pend_valid_reg) begin
               pend_valid_reg <= 1'b1;
               pend_addr_reg  <= addressin;
            end
         end
      end
   end

   assign addressout = addr_reg;
   assign request    = request_reg;
   assign stop       = stop_reg;
   assign busy       = busy_reg;
   assign bad_char   = bad_reg;

endmodule

// File: tb/tb_mix_char_out.sv
// Directed bench for mix_char_out: three instances with different geometry,
// a memory responder per instance and a serial receiver decoding tx.
module tb_mix_char_out;

   localparam int CPB = 4;
   localparam int N   = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [N-1:0]  start, request, load, stop, busy, bad_char, tx;
   logic [11:0]   addressin  [N];
   logic [11:0]   addressout [N];
   logic [29:0]   word_in    [N];

   logic [7:0]    rxq  [N][$];
   logic [11:0]   reqq [N][$];
   logic [7:0]    expq [$];

   int n_checks = 0;
   int n_errors = 0;

   // inst 0: WORDS=14 CRLF; inst 1: WORDS=2 LF TRIM; inst 2: WORDS=3 no EOL
   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int GW = (gi == 0) ? 14 : ((gi == 1) ? 2 : 3);
      localparam int GE = (gi == 0) ? 0  : ((gi == 1) ? 1 : 2);
      localparam int GT = (gi == 1) ? 1 : 0;
      mix_char_out #(
         .ADDR_W(12), .WORDS(GW), .CHARS(5), .CHAR_W(6),
         .EOL_MODE(GE), .TRIM(GT), .CLKS_PER_BIT(CPB)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start[gi]),
         .addressin  (addressin[gi]),
         .addressout (addressout[gi]),
         .request    (request[gi]),
         .load       (load[gi]),
         .in         (word_in[gi]),
         .stop       (stop[gi]),
         .busy       (busy[gi]),
         .bad_char   (bad_char[gi]),
         .tx         (tx[gi])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] pack5(input int c0, input int c1, input int c2,
                                         input int c3, input int c4);
      return {6'(c0), 6'(c1), 6'(c2), 6'(c3), 6'(c4)};
   endfunction

   // Memory contents seen by each instance
   function automatic logic [29:0] mem(input int inst, input logic [11:0] a);
      logic [29:0] w;
      w = '0;
      if (inst == 0) begin
         if (a == 12'd100)      w = pack5(8, 5, 13, 13, 16);   // HELLO
         else if (a == 12'd200) w = pack5(30, 31, 32, 0, 0);   // 012
         else if (a == 12'd300) w = pack5(1, 60, 2, 0, 0);     // A ? B
      end else if (inst == 1) begin
         if (a == 12'd50)       w = pack5(1, 0, 0, 2, 0);      // "A  B "
      end else begin
         w = pack5(1, 2, 3, 4, 5);                             // ABCDE
      end
      return w;
   endfunction

   // CPU memory responder: answer each request with a one-cycle load
   initial begin
      load = '0;
      for (int i = 0; i < N; i++) word_in[i] = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (request[i] && !load[i]) begin
               load[i]    = 1'b1;
               word_in[i] = mem(i, addressout[i]);
               reqq[i].push_back(addressout[i]);
            end else begin
               load[i] = 1'b0;
            end
         end
      end
   end

   // Serial receiver: sample the middle of each bit, CPB cycles per bit
   int         rx_tick [N];
   logic       rx_act  [N];
   logic [7:0] rx_sh   [N];
   initial begin
      for (int i = 0; i < N; i++) begin
         rx_tick[i] = 0; rx_act[i] = 1'b0; rx_sh[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!rx_act[i]) begin
               if (tx[i] == 1'b0) begin
                  rx_act[i]  = 1'b1;
                  rx_tick[i] = 0;
               end
            end else begin
               rx_tick[i]++;
               if (rx_tick[i] >= 6 && rx_tick[i] <= 34 && ((rx_tick[i] - 2) % 4) == 0)
                  rx_sh[i] = {tx[i], rx_sh[i][7:1]};
               if (rx_tick[i] == 38) begin
                  rxq[i].push_back(rx_sh[i]);
                  rx_act[i] = 1'b0;
               end
            end
         end
      end
   end

   task automatic exp_add(input logic [7:0] b, input int n);
      for (int k = 0; k < n; k++) expq.push_back(b);
   endtask

   task automatic expect_rx(input int inst, input string tag);
      int n;
      logic [7:0] got;
      n = rxq[inst].size();
      check_eq({tag, "_bytes"}, n, expq.size());
      for (int k = 0; k < expq.size(); k++) begin
         got = (rxq[inst].size() > 0) ? rxq[inst].pop_front() : 8'h00;
         check_eq($sformatf("%s_byte%0d", tag, k), got, expq[k]);
      end
      $display("block %s: %0d bytes received, %0d expected", tag, n, expq.size());
      expq.delete();
      rxq[inst].delete();
   endtask

   task automatic expect_addr(input int inst, input logic [11:0] first, input int n, input string tag);
      logic [11:0] got, e;
      check_eq({tag, "_nreq"}, reqq[inst].size(), n);
      for (int k = 0; k < n; k++) begin
         e   = first + 12'(k);
         got = (reqq[inst].size() > 0) ? reqq[inst].pop_front() : 12'hFFF;
         check_eq($sformatf("%s_addr%0d", tag, k), got, e);
      end
      reqq[inst].delete();
   endtask

   task automatic idle_start(input int inst, input logic [11:0] a, input string tag);
      addressin[inst] = a;
      start[inst]     = 1'b1;
      @(negedge clk);
      start[inst]     = 1'b0;
      addressin[inst] = '0;
      check_eq({tag, "_stop"}, stop[inst], 1);
      check_eq({tag, "_busy"}, busy[inst], 1);
      check_eq({tag, "_req"},  request[inst], 1);
      check_eq({tag, "_addr"}, addressout[inst], a);
   endtask

   task automatic wait_idle(input int inst, input string tag);
      int cyc;
      cyc = 0;
      while (busy[inst] && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, "_idle"}, busy[inst], 0);
      repeat (50) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic busy_drop;
      reset = 1'b1;
      start = '0;
      for (int i = 0; i < N; i++) addressin[i] = '0;
      repeat (45) @(negedge clk);
      for (int i = 0; i < N; i++) begin rxq[i].delete(); reqq[i].delete(); end

      // reset state
      check_eq("rst_busy", busy, 0);
      check_eq("rst_request", request, 0);
      check_eq("rst_stop", stop, 0);
      check_eq("rst_bad", bad_char, 0);
      check_eq("rst_tx", tx, 3'b111);
      check_eq("rst_addr", addressout[0], 0);
      reset = 1'b0;
      @(negedge clk);

      // block 1 at 100 with a second OUT queued at 200
      idle_start(0, 12'd100, "blk1");
      @(negedge clk);
      check_eq("blk1_stop_pulse", stop[0], 0);
      repeat (100) @(negedge clk);
      addressin[0] = 12'd200;
      start[0]     = 1'b1;
      @(negedge clk);
      start[0]     = 1'b0;
      addressin[0] = '0;
      check_eq("queued_no_stop", stop[0], 0);
      cyc = 0;
      busy_drop = 1'b0;
      while (!stop[0] && cyc < 10000) begin
         if (!busy[0]) busy_drop = 1'b1;
         @(negedge clk);
         cyc++;
      end
      check_eq("chain_stop", stop[0], 1);
      check_eq("chain_addr", addressout[0], 12'd200);
      check_eq("chain_busy", busy[0], 1);
      check_eq("chain_busy_gap", busy_drop, 0);
      check_eq("chain_after_cr", rxq[0].size(), 71);
      wait_idle(0, "blk2");
      exp_add(8'h48, 1); exp_add(8'h45, 1); exp_add(8'h4C, 2); exp_add(8'h4F, 1);
      exp_add(8'h20, 65); exp_add(8'h0D, 1); exp_add(8'h0A, 1);
      exp_add(8'h30, 1); exp_add(8'h31, 1); exp_add(8'h32, 1);
      exp_add(8'h20, 67); exp_add(8'h0D, 1); exp_add(8'h0A, 1);
      expect_rx(0, "blk12");
      check_eq("blk12_nreq", reqq[0].size(), 28);
      for (int k = 0; k < 28; k++) begin
         check_eq($sformatf("blk12_addr%0d", k), reqq[0].pop_front(),
                  (k < 14) ? 100 + k : 200 + k - 14);
      end
      reqq[0].delete();

      // undefined code 60
      idle_start(0, 12'd300, "badc");
      wait_idle(0, "badc");
      check_eq("badc_flag", bad_char[0], 1);
      exp_add(8'h41, 1); exp_add(8'h3F, 1); exp_add(8'h42, 1);
      exp_add(8'h20, 67); exp_add(8'h0D, 1); exp_add(8'h0A, 1);
      expect_rx(0, "badc");
      expect_addr(0, 12'd300, 14, "badc");

      // idle start clears the flag; then reset mid-block
      idle_start(0, 12'd100, "rst_blk");
      check_eq("bad_cleared", bad_char[0], 0);
      cyc = 0;
      while (rxq[0].size() < 3 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("rst_blk_3bytes", rxq[0].size(), 3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midrst_busy", busy[0], 0);
      check_eq("midrst_req", request[0], 0);
      check_eq("midrst_stop", stop[0], 0);
      repeat (60) @(negedge clk);
      check_eq("midrst_tx", tx[0], 1);
      rxq[0].delete();
      reqq[0].delete();
      idle_start(0, 12'd100, "restart");
      wait_idle(0, "restart");
      exp_add(8'h48, 1); exp_add(8'h45, 1); exp_add(8'h4C, 2); exp_add(8'h4F, 1);
      exp_add(8'h20, 65); exp_add(8'h0D, 1); exp_add(8'h0A, 1);
      expect_rx(0, "restart");
      expect_addr(0, 12'd100, 14, "restart");

      // trailing-blank suppression with LF terminator
      idle_start(1, 12'd50, "trim");
      wait_idle(1, "trim");
      exp_add(8'h41, 1); exp_add(8'h20, 2); exp_add(8'h42, 1); exp_add(8'h0A, 1);
      expect_rx(1, "trim");
      expect_addr(1, 12'd50, 2, "trim");

      // address wrap at 4095, no terminator
      idle_start(2, 12'd4095, "wrap");
      wait_idle(2, "wrap");
      for (int k = 0; k < 3; k++) begin
         exp_add(8'h41, 1); exp_add(8'h42, 1); exp_add(8'h43, 1);
         exp_add(8'h44, 1); exp_add(8'h45, 1);
      end
      expect_rx(2, "wrap");
      check_eq("wrap_nreq", reqq[2].size(), 3);
      check_eq("wrap_a0", reqq[2].pop_front(), 12'd4095);
      check_eq("wrap_a1", reqq[2].pop_front(), 12'd0);
      check_eq("wrap_a2", reqq[2].pop_front(), 12'd1);
      check_eq("wrap_tx_idle", tx[2], 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mix_char_out.md
Name: mix_char_out

Overview:
- Parametrised MIX character-output unit, the next generation of the single-format teletype/tape output block.
- On an OUT command it fetches a block of WORDS words from CPU memory, one word per request/load handshake.
- Each word's 6-bit MIX character codes are converted to 7-bit ASCII and sent over the UART transmitter, followed by a configurable line terminator.
- New over the previous unit:
  - block length, word/char geometry and terminator are parameters;
  - optional trailing-blank suppression;
  - undefined-code flagging.

Parameters:
- ADDR_W, 12, memory address width.
- WORDS, 14, words per block (line); must be ≥1.
- CHARS, 5, characters per word.
- CHAR_W, 6, bits per MIX character; word width is CHARS*CHAR_W.
- EOL_MODE, 0, line terminator: 0 = CR LF, 1 = LF only, 2 = none.
- TRIM, 0, 1 = suppress trailing blanks (code 0) before the terminator.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle OUT command from the CPU.
- addressin, in, ADDR_W, block start address; valid with start.
- addressout, out, ADDR_W, address of the word requested.
- request, out, 1, word request to the CPU.
- load, in, 1, CPU word strobe; data on in is valid.
- in, in, CHARS*CHAR_W, word data, MSB character first.
- stop, out, 1, one-cycle pulse: the CPU may resume.
- busy, out, 1, unit is transmitting a block.
- bad_char, out, 1, sticky flag: a code ≥56 was seen; cleared on reset or on an idle start.
- tx, out, 1, UART serial line; idles high.

Behaviour:
- Reset: busy, request, stop, bad_char, addressout and all counters/pointers = 0; pending block empty; tx high.
- Idle start (busy=0, start=1), next cycle:
  - busy=1, stop=1 for one cycle, request=1, addressout=addressin;
  - word counter, char counter, blank counter and bad_char = 0.
- Busy start with pending slot empty: latch addressin into the pending slot; stop is withheld.
- Busy start with pending slot full: ignored (the CPU is stalled because stop is withheld).
- Word handshake: request stays high until a cycle with load&request.
  - That cycle: word register <- in, request <- 0, run <- 1.
  - load without request is ignored.
- Character send: while run=1 and UART ready=1, issue one UART load for the current character, then advance the char counter.
  - Character slot k maps to in[(CHARS-k)*CHAR_W-1 -: CHAR_W].
- Translation: the MIX→ASCII table is 56 entries, as in the current unit (0 → space, 10 → LF, 20 → CR, 21 → BEL).
  - Codes ≥56 transmit '?' (63) and set bad_char.
- End of word (not last word): request <- 1, addressout <- addressout+1, wrapping modulo 2^ADDR_W.
- Last word: after its chars, emit the terminator per EOL_MODE (0, 1 or 2 extra UART bytes), then end the block.
- TRIM=1:
  - A blank is not sent; it increments a blank counter of width clog2(WORDS*CHARS+1).
  - When a non-blank character is next to be sent, first send the counted blanks one per UART ready, decrementing, then send the character.
  - At end of block, discard the counter (trailing blanks are never sent).
- End of block with pending slot empty: busy <- 0, run <- 0, idle.
- End of block with pending slot full, in one cycle:
  - addressout <- pending address, pending cleared, request <- 1;
  - counters reset, stop pulses for one cycle, busy stays 1.
- Simultaneous start and end of block, same cycle: the new start is treated as a pending-slot write and is then consumed immediately as the next block (stop pulses once, no block is lost).
- Reset mid-block: aborts at once.
  - tx returns high after the UART's own reset.
  - A partly sent byte is truncated; this is accepted.
- UART latency: the next UART load is issued no earlier than the cycle ready reasserts.

Decomposition:
- Shared package (mix_io_pkg):
  - MIX char code constants: BLANK=0, LF_CODE=10, CR_CODE=20;
  - ASCII_CR=13, ASCII_LF=10, ASCII_BAD=63;
  - EOL_MODE enumeration.
- Sub-module mix_to_ascii: combinational 6→7-bit table plus a valid bit.
- The existing UartTX is instantiated unchanged.

Test Plan:
- WORDS=14, EOL_MODE=0: idle start addr=100, words encode "HELLO" then blanks → stop pulse one cycle after start; addresses 100..113 requested; UART bytes 48 45 4C 4C 4F, 65×20h, 0D 0A; busy then drops.
- Second start during block 1 (addr=200) → no stop until block 1's LF is sent; then stop pulses, addressout=200, busy never drops between blocks.
- TRIM=1, EOL_MODE=1, WORDS=2: words "A  B " and "     " → bytes 41 20 20 42 0A exactly.
- Word containing code 60 → '?' (3Fh) sent; bad_char=1 until the next idle start.
- ADDR_W=12, start addr=4095, WORDS=3 → addressout sequence 4095, 0, 1.
- Reset asserted after 3 bytes of block 1 → next cycle busy=0, request=0, stop=0; a fresh start restarts cleanly from addressin.
